time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Time-setting controller for the digital clock. It sequences the user through the hour, minute and second fields using a mode button, and edits the selected field in BCD with increment/decrement buttons. It blinks the selected field on the seven-segment display and commits the edited time to the time counter with a one-cycle load pulse. It sits between the time counter (cur_* in, set_*/load/hold out) and the display decoder (disp_*/blank out).

Parameters:
HOUR_MAX, 23, highest hour value; hour field wraps HOUR_MAX<->0
TIMEOUT_TICKS, 20, number of blink_tick pulses with no button press before the set session aborts
TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_TICKS

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
blink_tick  in  1  single-cycle pulse at the blink rate (2 Hz)
btn_mode  in  1  debounced single-cycle pulse; advances the set mode
btn_inc  in  1  debounced single-cycle pulse; increments the selected field
btn_dec  in  1  debounced single-cycle pulse; decrements the selected field
cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi  in  4 each  live BCD time from the counter
set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi  out  4 each  edited BCD time; valid when load=1
load  out  1  one-cycle pulse; counter loads set_*
hold  out  1  counter pause; high while a set session is active
disp_sec_ge ... disp_hour_shi  out  4 each  BCD digits to the display decoder (same six-digit order as cur_*)
blank  out  6  per-digit blank, bit0=sec_ge ... bit5=hour_shi; 1 = digit dark

Behaviour:
- Reset is asynchronous, active-low, on clk and rst_n as already decided. Reset values:
  - state=RUN
  - all set_* = 0
  - load=0, hold=0, blank=0
  - blink phase=0, timeout counter=0
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN:
  - disp_* = cur_* combinationally, with zero latency. blank=0, hold=0.
  - On btn_mode: capture cur_* into set_* in the same edge and go to SET_HOUR.
- SET_HOUR -> btn_mode -> SET_MIN -> btn_mode -> SET_SEC -> btn_mode -> COMMIT.
- COMMIT lasts exactly one cycle with load=1 and hold=1, then returns to RUN. The counter sees load on the same cycle set_* is final.
- hold=1 in SET_HOUR, SET_MIN, SET_SEC and COMMIT; hold is registered from the state.
- In set states, disp_* = set_*.
- Field arithmetic operates on the two-digit BCD value of the selected field:
  - Hour: inc HOUR_MAX->00, dec 00->HOUR_MAX.
  - Minute and second: inc 59->00, dec 00->59.
  - Result is written back as two BCD digits; the ge digit never exceeds 9.
  - Unselected fields are unchanged.
- Simultaneous button events:
  - btn_inc and btn_dec together: no change.
  - btn_mode with inc or dec: mode wins and the field is not modified.
  - Buttons in COMMIT are ignored. btn_inc/btn_dec in RUN are ignored.
- Blink:
  - Phase toggles on each blink_tick while in a set state.
  - Phase is forced to 0 on state entry and on any accepted inc/dec, so the field is visible right after an edit.
  - blank bits for the selected field's two digits = phase; all other bits 0. blank is combinational from state and phase.
- Timeout:
  - Counter is cleared on entry to SET_HOUR and on any btn_mode, btn_inc or btn_dec.
  - It increments on each blink_tick in set states.
  - When it reaches TIMEOUT_TICKS, go to RUN directly with no load pulse; the edits are discarded.
  - A button press in the same cycle as the final tick takes priority: the counter clears and the timeout does not fire.
- Out-of-range captured cur_* values (non-BCD) are copied as-is. The first inc/dec on that field treats the value >max as wrapping to 00 for inc, and to max for dec.
- Reset mid-session returns to RUN immediately. No load is issued.

Test Plan:
1. Reset, cur=12:34:56, no buttons -> disp=12:34:56, blank=0, hold=0, load=0.
2. btn_mode, then btn_inc×12 -> hour 12->23->00 (wraps after 11 incs, the 12th gives 00). disp hour=00, hold=1, blank[5:4] toggles every blink_tick.
3. In SET_MIN from 34: btn_dec×35 -> 59. btn_mode×2 -> exactly one load cycle with set=00:59:56, then state RUN and hold=0 on the next cycle.
4. In SET_SEC, pulse btn_inc and btn_dec together, then btn_mode with btn_inc together -> seconds unchanged; the state advances to COMMIT.
5. Enter SET_HOUR, apply 20 blink_ticks with no buttons -> return to RUN, load never asserted, disp follows cur. Repeat with btn_inc on the 20th tick -> session stays active.
6. Assert rst_n low during SET_MIN -> hold=0, blank=0, set_*=0 immediately. After release the state is RUN and no load occurs.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
// Bundle of the button, live-time, edited-time and display signals around the
// time-setting controller. master = surrounding system/bench, slave = controller.
interface time_set_ctrl_if;
  // Protocol: blink_tick and btn_* are single-cycle pulses sampled on clk.
  // load is a single-cycle pulse and set_* is stable and final in that cycle;
  // hold stays high for the whole session including the load cycle.
  logic       blink_tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [3:0] cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi;
  logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic       load;
  logic       hold;
  logic [3:0] disp_sec_ge, disp_sec_shi, disp_min_ge, disp_min_shi, disp_hour_ge, disp_hour_shi;
  logic [5:0] blank;
  logic [2:0] dbg_state;

  modport master (
    output blink_tick, btn_mode, btn_inc, btn_dec,
    output cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
    input  set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
    input  load, hold,
    input  disp_sec_ge, disp_sec_shi, disp_min_ge, disp_min_shi, disp_hour_ge, disp_hour_shi,
    input  blank, dbg_state
  );

  modport slave (
    input  blink_tick, btn_mode, btn_inc, btn_dec,
    input  cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
    output set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
    output load, hold,
    output disp_sec_ge, disp_sec_shi, disp_min_ge, disp_min_shi, disp_hour_ge, disp_hour_shi,
    output blank, dbg_state
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: walks hour/minute/second with btn_mode, edits the
// selected field in BCD, blinks it, and commits to the counter with a load pulse.
module time_set_ctrl #(
  parameter int HOUR_MAX      = 23,
  parameter int TIMEOUT_TICKS = 20,
  parameter int TO_W          = 5
) (
  input logic            clk,
  input logic            rst_n,
  time_set_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic            load, hold;
  logic            phase;
  logic [TO_W-1:0] to_cnt;

  logic       in_set, any_btn, edit, edit_inc, tick_to;
  logic [3:0] fld_shi, fld_ge, new_shi, new_ge;
  logic [7:0] fld_max, fld_val, new_val;

  assign in_set   = (state == ST_SET_HOUR) || (state == ST_SET_MIN) || (state == ST_SET_SEC);
  assign any_btn  = bus.btn_mode | bus.btn_inc | bus.btn_dec;
  assign edit_inc = bus.btn_inc & ~bus.btn_dec;
  // inc+dec together cancel; mode beats any edit in the same cycle
  assign edit     = in_set & ~bus.btn_mode & (bus.btn_inc ^ bus.btn_dec);
  assign tick_to  = in_set & ~any_btn & bus.blink_tick &
                    (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

  always_comb begin
    fld_shi = set_sec_shi;
    fld_ge  = set_sec_ge;
    fld_max = 8'd59;
    case (state)
      ST_SET_HOUR: begin
        fld_shi = set_hour_shi;
        fld_ge  = set_hour_ge;
        fld_max = 8'(HOUR_MAX);
      end
      ST_SET_MIN: begin
        fld_shi = set_min_shi;
        fld_ge  = set_min_ge;
      end
      default: ;
    endcase
  end

  // Non-BCD captures can exceed max; they wrap like max would.
  assign fld_val = 8'(fld_shi) * 8'd10 + 8'(fld_ge);
  always_comb begin
    if (edit_inc) new_val = (fld_val >= fld_max) ? 8'd0 : fld_val + 8'd1;
    else          new_val = (fld_val == 8'd0 || fld_val > fld_max) ? fld_max : fld_val - 8'd1;
  end
  assign new_shi = 4'(new_val / 8'd10);
  assign new_ge  = 4'(new_val % 8'd10);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (bus.btn_mode) state_nxt = ST_SET_HOUR;
      ST_SET_HOUR: if (bus.btn_mode) state_nxt = ST_SET_MIN;
                   else if (tick_to) state_nxt = ST_RUN;
      ST_SET_MIN:  if (bus.btn_mode) state_nxt = ST_SET_SEC;
                   else if (tick_to) state_nxt = ST_RUN;
      ST_SET_SEC:  if (bus.btn_mode) state_nxt = ST_COMMIT;
                   else if (tick_to) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      load         <= 1'b0;
      hold         <= 1'b0;
      phase        <= 1'b0;
      to_cnt       <= '0;
      set_sec_ge   <= '0;
      set_sec_shi  <= '0;
      set_min_ge   <= '0;
      set_min_shi  <= '0;
      set_hour_ge  <= '0;
      set_hour_shi <= '0;
    end else begin
      state <= state_nxt;
      hold  <= (state_nxt != ST_RUN);
      load  <= (state_nxt == ST_COMMIT);

      if (state == ST_RUN && bus.btn_mode) begin
        set_sec_ge   <= bus.cur_sec_ge;
        set_sec_shi  <= bus.cur_sec_shi;
        set_min_ge   <= bus.cur_min_ge;
        set_min_shi  <= bus.cur_min_shi;
        set_hour_ge  <= bus.cur_hour_ge;
        set_hour_shi <= bus.cur_hour_shi;
      end else if (edit) begin
        case (state)
          ST_SET_HOUR: begin set_hour_shi <= new_shi; set_hour_ge <= new_ge; end
          ST_SET_MIN:  begin set_min_shi  <= new_shi; set_min_ge  <= new_ge; end
          default:     begin set_sec_shi  <= new_shi; set_sec_ge  <= new_ge; end
        endcase
      end

      // Phase restarts dark-free after every entry or edit so the new value shows.
      if (!in_set || bus.btn_mode || edit || tick_to) phase <= 1'b0;
      else if (bus.blink_tick)                        phase <= ~phase;

      if (!in_set || any_btn || tick_to) to_cnt <= '0;
      else if (bus.blink_tick)           to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    if (state == ST_RUN) begin
      bus.disp_sec_ge   = bus.cur_sec_ge;
      bus.disp_sec_shi  = bus.cur_sec_shi;
      bus.disp_min_ge   = bus.cur_min_ge;
      bus.disp_min_shi  = bus.cur_min_shi;
      bus.disp_hour_ge  = bus.cur_hour_ge;
      bus.disp_hour_shi = bus.cur_hour_shi;
    end else begin
      bus.disp_sec_ge   = set_sec_ge;
      bus.disp_sec_shi  = set_sec_shi;
      bus.disp_min_ge   = set_min_ge;
      bus.disp_min_shi  = set_min_shi;
      bus.disp_hour_ge  = set_hour_ge;
      bus.disp_hour_shi = set_hour_shi;
    end
  end

  always_comb begin
    bus.blank = 6'b000000;
    case (state)
      ST_SET_HOUR: bus.blank[5:4] = {phase, phase};
      ST_SET_MIN:  bus.blank[3:2] = {phase, phase};
      ST_SET_SEC:  bus.blank[1:0] = {phase, phase};
      default: ;
    endcase
  end

  assign bus.set_sec_ge   = set_sec_ge;
  assign bus.set_sec_shi  = set_sec_shi;
  assign bus.set_min_ge   = set_min_ge;
  assign bus.set_min_shi  = set_min_shi;
  assign bus.set_hour_ge  = set_hour_ge;
  assign bus.set_hour_shi = set_hour_shi;
  assign bus.load         = load;
  assign bus.hold         = hold;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: session walk, BCD wraps, blink, commit,
// timeout, button collisions, non-BCD capture and mid-session reset.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] S_RUN = 3'd0, S_HOUR = 3'd1, S_MIN = 3'd2, S_SEC = 3'd3, S_COMMIT = 3'd4;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.HOUR_MAX(23), .TIMEOUT_TICKS(20), .TO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [23:0] disp_v, set_v;
  assign disp_v = {bus.disp_hour_shi, bus.disp_hour_ge, bus.disp_min_shi,
                   bus.disp_min_ge, bus.disp_sec_shi, bus.disp_sec_ge};
  assign set_v  = {bus.set_hour_shi, bus.set_hour_ge, bus.set_min_shi,
                   bus.set_min_ge, bus.set_sec_shi, bus.set_sec_ge};

  task automatic set_cur(input logic [23:0] v);
    {bus.cur_hour_shi, bus.cur_hour_ge, bus.cur_min_shi,
     bus.cur_min_ge, bus.cur_sec_shi, bus.cur_sec_ge} = v;
  endtask

  // One clock of button/tick activity; returns #1 after the edge with inputs idle.
  task automatic step(input logic m, input logic i, input logic d, input logic t);
    @(negedge clk);
    bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d; bus.blink_tick = t;
    @(posedge clk);
    #1;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.blink_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_cur(24'h123456);
    repeat (2) @(negedge clk);
    checks++; if (set_v !== 24'h000000 || bus.load !== 1'b0 || bus.hold !== 1'b0) begin
      errors++; $display("FAIL reset_regs: set=%h load=%b hold=%b, want 000000 0 0", set_v, bus.load, bus.hold);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (disp_v !== 24'h123456 || bus.blank !== 6'b0 || bus.dbg_state !== S_RUN) begin
      errors++; $display("FAIL run_disp: disp=%h blank=%b st=%0d, want 123456 0 0", disp_v, bus.blank, bus.dbg_state);
    end
    set_cur(24'h235959);
    #1;
    checks++; if (disp_v !== 24'h235959) begin
      errors++; $display("FAIL run_passthru: disp=%h want 235959", disp_v);
    end
    set_cur(24'h123456);
  endtask

  task automatic test_hour_edit();
    step(1, 0, 0, 0);
    checks++; if (bus.dbg_state !== S_HOUR || bus.hold !== 1'b1 || set_v !== 24'h123456 || bus.blank !== 6'b0) begin
      errors++; $display("FAIL enter_hour: st=%0d hold=%b set=%h blank=%b, want 1 1 123456 0", bus.dbg_state, bus.hold, set_v, bus.blank);
    end
    for (int k = 0; k < 11; k++) step(0, 1, 0, 0);
    checks++; if (disp_v !== 24'h233456) begin
      errors++; $display("FAIL hour_inc_23: disp=%h want 233456", disp_v);
    end
    step(0, 1, 0, 0);
    checks++; if (disp_v !== 24'h003456 || bus.load !== 1'b0) begin
      errors++; $display("FAIL hour_wrap_00: disp=%h load=%b want 003456 0", disp_v, bus.load);
    end
    step(0, 0, 0, 1);
    checks++; if (bus.blank !== 6'b110000) begin
      errors++; $display("FAIL blink_on: blank=%b want 110000", bus.blank);
    end
    step(0, 0, 0, 1);
    checks++; if (bus.blank !== 6'b000000) begin
      errors++; $display("FAIL blink_off: blank=%b want 000000", bus.blank);
    end
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    checks++; if (disp_v !== 24'h233456 || bus.blank !== 6'b000000) begin
      errors++; $display("FAIL hour_dec_wrap: disp=%h blank=%b want 233456 000000", disp_v, bus.blank);
    end
    step(0, 1, 0, 0);
    checks++; if (disp_v !== 24'h003456) begin
      errors++; $display("FAIL hour_inc_back: disp=%h want 003456", disp_v);
    end
  endtask

  task automatic test_min_commit();
    step(1, 0, 0, 0);
    checks++; if (bus.dbg_state !== S_MIN || bus.blank !== 6'b0) begin
      errors++; $display("FAIL enter_min: st=%0d blank=%b want 2 0", bus.dbg_state, bus.blank);
    end
    for (int k = 0; k < 34; k++) step(0, 0, 1, 0);
    checks++; if (disp_v !== 24'h000056) begin
      errors++; $display("FAIL min_dec_00: disp=%h want 000056", disp_v);
    end
    step(0, 0, 1, 0);
    checks++; if (disp_v !== 24'h005956) begin
      errors++; $display("FAIL min_wrap_59: disp=%h want 005956", disp_v);
    end
    step(0, 0, 0, 1);
    checks++; if (bus.blank !== 6'b001100) begin
      errors++; $display("FAIL min_blink: blank=%b want 001100", bus.blank);
    end
    step(1, 0, 0, 0);
    checks++; if (bus.dbg_state !== S_SEC || bus.load !== 1'b0 || bus.blank !== 6'b0) begin
      errors++; $display("FAIL enter_sec: st=%0d load=%b blank=%b want 3 0 0", bus.dbg_state, bus.load, bus.blank);
    end
    step(1, 0, 0, 0);
    checks++; if (bus.load !== 1'b1 || bus.hold !== 1'b1 || set_v !== 24'h005956 || bus.dbg_state !== S_COMMIT) begin
      errors++; $display("FAIL commit: load=%b hold=%b set=%h st=%0d want 1 1 005956 4", bus.load, bus.hold, set_v, bus.dbg_state);
    end
    step(0, 0, 0, 0);
    checks++; if (bus.load !== 1'b0 || bus.hold !== 1'b0 || bus.dbg_state !== S_RUN || disp_v !== 24'h123456) begin
      errors++; $display("FAIL after_commit: load=%b hold=%b st=%0d disp=%h want 0 0 0 123456", bus.load, bus.hold, bus.dbg_state, disp_v);
    end
  endtask

  task automatic test_collisions();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    checks++; if (set_v !== 24'h123456 || bus.dbg_state !== S_SEC) begin
      errors++; $display("FAIL inc_dec_together: set=%h st=%0d want 123456 3", set_v, bus.dbg_state);
    end
    step(1, 1, 0, 0);
    checks++; if (set_v !== 24'h123456 || bus.dbg_state !== S_COMMIT || bus.load !== 1'b1) begin
      errors++; $display("FAIL mode_beats_inc: set=%h st=%0d load=%b want 123456 4 1", set_v, bus.dbg_state, bus.load);
    end
    step(0, 1, 0, 0);
    checks++; if (bus.dbg_state !== S_RUN || set_v !== 24'h123456 || bus.load !== 1'b0) begin
      errors++; $display("FAIL commit_ignores_btn: st=%0d set=%h load=%b want 0 123456 0", bus.dbg_state, set_v, bus.load);
    end
    step(0, 1, 1, 0);
    checks++; if (bus.dbg_state !== S_RUN || set_v !== 24'h123456) begin
      errors++; $display("FAIL run_ignores_edit: st=%0d set=%h want 0 123456", bus.dbg_state, set_v);
    end
  endtask

  task automatic test_timeout();
    int load_seen;
    load_seen = 0;
    step(1, 0, 0, 0);
    for (int k = 0; k < 19; k++) begin
      step(0, 0, 0, 1);
      if (bus.load) load_seen++;
    end
    checks++; if (bus.dbg_state !== S_HOUR || bus.hold !== 1'b1) begin
      errors++; $display("FAIL before_timeout: st=%0d hold=%b want 1 1", bus.dbg_state, bus.hold);
    end
    step(0, 0, 0, 1);
    if (bus.load) load_seen++;
    checks++; if (bus.dbg_state !== S_RUN || bus.hold !== 1'b0 || load_seen !== 0) begin
      errors++; $display("FAIL timeout_fire: st=%0d hold=%b loads=%0d want 0 0 0", bus.dbg_state, bus.hold, load_seen);
    end
    set_cur(24'h081530);
    #1;
    checks++; if (disp_v !== 24'h081530 || bus.blank !== 6'b0) begin
      errors++; $display("FAIL timeout_disp: disp=%h blank=%b want 081530 0", disp_v, bus.blank);
    end
    step(1, 0, 0, 0);
    for (int k = 0; k < 19; k++) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    checks++; if (bus.dbg_state !== S_HOUR || disp_v !== 24'h091530) begin
      errors++; $display("FAIL btn_on_last_tick: st=%0d disp=%h want 1 091530", bus.dbg_state, disp_v);
    end
    for (int k = 0; k < 19; k++) step(0, 0, 0, 1);
    checks++; if (bus.dbg_state !== S_HOUR) begin
      errors++; $display("FAIL timeout_restarted: st=%0d want 1", bus.dbg_state);
    end
    step(0, 0, 0, 1);
    checks++; if (bus.dbg_state !== S_RUN || bus.load !== 1'b0) begin
      errors++; $display("FAIL timeout_second: st=%0d load=%b want 0 0", bus.dbg_state, bus.load);
    end
  endtask

  task automatic test_non_bcd();
    set_cur(24'h127AF3);
    step(1, 0, 0, 0);
    checks++; if (set_v !== 24'h127AF3 || disp_v !== 24'h127AF3) begin
      errors++; $display("FAIL raw_capture: set=%h disp=%h want 127af3", set_v, disp_v);
    end
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++; if (set_v !== 24'h1200F3) begin
      errors++; $display("FAIL raw_inc: set=%h want 1200f3", set_v);
    end
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++; if (set_v !== 24'h120059) begin
      errors++; $display("FAIL raw_dec: set=%h want 120059", set_v);
    end
    step(1, 0, 0, 0);
    checks++; if (bus.load !== 1'b1 || set_v !== 24'h120059) begin
      errors++; $display("FAIL raw_commit: load=%b set=%h want 1 120059", bus.load, set_v);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int load_seen;
    load_seen = 0;
    set_cur(24'h123456);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    checks++; if (bus.dbg_state !== S_MIN || bus.blank !== 6'b001100 || set_v !== 24'h123556) begin
      errors++; $display("FAIL pre_reset: st=%0d blank=%b set=%h want 2 001100 123556", bus.dbg_state, bus.blank, set_v);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.hold !== 1'b0 || bus.blank !== 6'b0 || set_v !== 24'h0 || bus.dbg_state !== S_RUN) begin
      errors++; $display("FAIL async_reset: hold=%b blank=%b set=%h st=%0d want 0 0 000000 0", bus.hold, bus.blank, set_v, bus.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1);
      if (bus.load) load_seen++;
    end
    checks++; if (bus.dbg_state !== S_RUN || load_seen !== 0 || disp_v !== 24'h123456) begin
      errors++; $display("FAIL post_reset: st=%0d loads=%0d disp=%h want 0 0 123456", bus.dbg_state, load_seen, disp_v);
    end
  endtask

  initial begin
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.blink_tick = 1'b0;
    set_cur(24'h000000);
    test_reset();
    test_hour_edit();
    test_min_commit();
    test_collisions();
    test_timeout();
    test_non_bcd();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
